// File: rtl/apb_pkg.sv
// Shared types and default sizing for the APB master and its wait counter.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

    localparam int unsigned DEF_ADDR_W  = 8;
    localparam int unsigned DEF_DATA_W  = 32;
    localparam int unsigned DEF_TIMEOUT = 16;
    localparam int unsigned WAIT_CNT_W  = 8;

endpackage

// File: rtl/apb_wait_cnt.sv
// Counts ACCESS cycles without pready; expired flags that the current cycle
// is the last one allowed before forced termination.
module apb_wait_cnt
    import apb_pkg::*;
#(
    parameter int unsigned LIMIT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [WAIT_CNT_W-1:0] LIMIT_M1 = WAIT_CNT_W'(LIMIT - 1);

    logic [WAIT_CNT_W-1:0] cnt_r;
    logic [WAIT_CNT_W-1:0] cnt_nxt_s;
    logic                  expired_r;

    // Next count: clear wins over increment.
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (clr) begin
            cnt_nxt_s = '0;
        end else if (en) begin
            cnt_nxt_s = cnt_r + 8'd1;
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Count register; expired is precomputed so it is valid from the first ACCESS cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r     <= '0;
            expired_r <= 1'b0;
        end else begin
            cnt_r     <= cnt_nxt_s;
            expired_r <= (cnt_nxt_s == LIMIT_M1);
        end
    end

    assign expired = expired_r;

endmodule

// File: rtl/apb_master.sv
// Single-outstanding APB master: host request in, one APB transfer out,
// one-cycle response pulse back. Stalled slaves are cut off after TIMEOUT waits.
module apb_master
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic              pready,
    input  logic              pslver,
    input  logic [DATA_W-1:0] prdata
);

    apb_state_t        state_r;
    apb_state_t        state_nxt_s;
    logic              accept_s;
    logic              done_s;
    logic              tmo_s;
    logic              expired_s;
    logic              req_ready_r;
    logic              rsp_valid_r;
    logic [DATA_W-1:0] rsp_rdata_r;
    logic              rsp_err_r;
    logic              psel_r;
    logic              penable_r;
    logic              pwrite_r;
    logic [ADDR_W-1:0] paddr_r;
    logic [DATA_W-1:0] pwdata_r;

    apb_wait_cnt #(
        .LIMIT (TIMEOUT)
    ) u_wait_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr     (state_r == SETUP),
        .en      ((state_r == ACCESS) && !pready),
        .expired (expired_s)
    );

    // Next-state logic; pready takes priority over the timeout.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        done_s      = 1'b0;
        tmo_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (req_valid && req_ready_r) begin
                    accept_s    = 1'b1;
                    state_nxt_s = SETUP;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SETUP: begin
                state_nxt_s = ACCESS;
            end
            ACCESS: begin
                if (pready) begin
                    done_s      = 1'b1;
                    state_nxt_s = IDLE;
                end else if (expired_s) begin
                    tmo_s       = 1'b1;
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = ACCESS;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State and registered outputs; control outputs decode the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            req_ready_r <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= '0;
            rsp_err_r   <= 1'b0;
            psel_r      <= 1'b0;
            penable_r   <= 1'b0;
            pwrite_r    <= 1'b0;
            paddr_r     <= '0;
            pwdata_r    <= '0;
        end else begin
            state_r     <= state_nxt_s;
            req_ready_r <= (state_nxt_s == IDLE);
            psel_r      <= (state_nxt_s != IDLE);
            penable_r   <= (state_nxt_s == ACCESS);
            rsp_valid_r <= done_s | tmo_s;
            if (accept_s) begin
                pwrite_r <= req_write;
                paddr_r  <= req_addr;
                pwdata_r <= req_write ? req_wdata : '0;
            end
            // Slave error keeps the read data it came with; timeouts have none.
            if (done_s) begin
                rsp_err_r   <= pslver;
                rsp_rdata_r <= pwrite_r ? '0 : prdata;
            end else if (tmo_s) begin
                rsp_err_r   <= 1'b1;
                rsp_rdata_r <= '0;
            end
        end
    end

    assign req_ready = req_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_err   = rsp_err_r;
    assign psel      = psel_r;
    assign penable   = penable_r;
    assign pwrite    = pwrite_r;
    assign paddr     = paddr_r;
    assign pwdata    = pwdata_r;

endmodule

// File: tb/tb_apb_master.sv
// Scenario-per-task bench for apb_master with a transaction-level reference model.
module tb_apb_master;

    localparam int AW  = 8;
    localparam int DW  = 32;
    localparam int TMO = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic          pready;
    logic          pslver;
    logic [DW-1:0] prdata;

    int n_cmp = 0;
    int n_err = 0;

    apb_master #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .TIMEOUT (TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .pready    (pready),
        .pslver    (pslver),
        .prdata    (prdata)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({req_ready, rsp_valid, rsp_err, rsp_rdata, psel, penable, pwrite, paddr, pwdata} !== '0) begin
            n_err++;
            $display("FAIL reset_values: got rdy=%b rv=%b err=%b rd=%h psel=%b pen=%b pw=%b pa=%h pwd=%h, want all 0",
                     req_ready, rsp_valid, rsp_err, rsp_rdata, psel, penable, pwrite, paddr, pwdata);
        end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({req_ready, psel, rsp_valid} !== 3'b100) begin
            n_err++;
            $display("FAIL reset_release: got rdy=%b psel=%b rv=%b, want 1 0 0", req_ready, psel, rsp_valid);
        end
    endtask

    // One full transfer; waits = ACCESS cycles with pready low before pready rises.
    task automatic do_txn(input string nm, input logic wr, input logic [AW-1:0] ad,
                          input logic [DW-1:0] wd, input int waits, input logic slv,
                          input logic [DW-1:0] rd);
        bit            timed_out;
        int            exp_acc;
        logic          exp_err;
        logic [DW-1:0] exp_rd;
        logic [DW-1:0] exp_pw;
        int            acc;
        bit            done;
        timed_out = (waits >= TMO);
        exp_acc   = timed_out ? TMO : waits + 1;
        exp_err   = timed_out ? 1'b1 : slv;
        exp_rd    = (timed_out || wr) ? '0 : rd;
        exp_pw    = wr ? wd : '0;

        @(negedge clk);
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL %s idle_ready: got %b want 1", nm, req_ready);
        end
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = ad;
        req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = AW'($urandom);
        req_wdata = $urandom;
        @(negedge clk);
        n_cmp++;
        if ({psel, penable, pwrite, paddr, pwdata, req_ready} !== {1'b1, 1'b0, wr, ad, exp_pw, 1'b0}) begin
            n_err++;
            $display("FAIL %s setup: got psel=%b pen=%b pw=%b pa=%h pwd=%h rdy=%b want 1 0 %b %h %h 0",
                     nm, psel, penable, pwrite, paddr, pwdata, req_ready, wr, ad, exp_pw);
        end
        pready = 1'(($urandom));
        pslver = 1'(($urandom));
        prdata = $urandom;

        acc  = 0;
        done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (psel && penable) begin
                acc++;
                n_cmp++;
                if ({pwrite, paddr, pwdata, rsp_valid} !== {wr, ad, exp_pw, 1'b0}) begin
                    n_err++;
                    $display("FAIL %s access_stable: got pw=%b pa=%h pwd=%h rv=%b want %b %h %h 0",
                             nm, pwrite, paddr, pwdata, rsp_valid, wr, ad, exp_pw);
                end
                if (acc > waits) begin
                    pready = 1'b1;
                    pslver = slv;
                    prdata = rd;
                end else begin
                    pready = 1'b0;
                    pslver = 1'(($urandom));
                    prdata = $urandom;
                end
            end else begin
                done = 1'b1;
            end
        end
        pready = 1'b0;
        pslver = 1'b0;

        n_cmp++;
        if (!done) begin
            n_err++;
            $display("FAIL %s bound: transfer did not end, got %0d access cycles", nm, acc);
        end
        n_cmp++;
        if (acc != exp_acc) begin
            n_err++;
            $display("FAIL %s access_len: got %0d want %0d", nm, acc, exp_acc);
        end
        n_cmp++;
        if ({rsp_valid, rsp_err, rsp_rdata, psel, penable, req_ready} !== {1'b1, exp_err, exp_rd, 1'b0, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL %s response: got rv=%b err=%b rd=%h psel=%b pen=%b rdy=%b want 1 %b %h 0 0 1",
                     nm, rsp_valid, rsp_err, rsp_rdata, psel, penable, req_ready, exp_err, exp_rd);
        end
        @(negedge clk);
        n_cmp++;
        if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b0, exp_err, exp_rd}) begin
            n_err++;
            $display("FAIL %s rsp_hold: got rv=%b err=%b rd=%h want 0 %b %h",
                     nm, rsp_valid, rsp_err, rsp_rdata, exp_err, exp_rd);
        end
    endtask

    task automatic test_directed();
        do_txn("write_zero_wait", 1'b1, 8'h10, 32'hDEADBEEF, 0, 1'b0, 32'h0);
        do_txn("read_3_waits", 1'b0, 8'h10, 32'h0, 3, 1'b0, 32'hDEADBEEF);
        do_txn("read_slverr", 1'b0, 8'h10, 32'h0, 0, 1'b1, 32'hDEADBEEF);
        do_txn("read_timeout", 1'b0, 8'h20, 32'h0, 255, 1'b0, 32'h12345678);
        do_txn("write_timeout_edge", 1'b1, 8'h21, 32'hA5A5A5A5, TMO, 1'b0, 32'h0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            do_txn("random", 1'(($urandom)), AW'($urandom), $urandom,
                   int'($urandom_range(0, TMO + 1)), 1'(($urandom)), $urandom);
        end
    endtask

    task automatic test_reset_mid_access();
        bit seen;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 8'h33;
        pready    = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 5 && !seen; c++) begin
            @(negedge clk);
            seen = psel && penable;
        end
        n_cmp++;
        if (!seen) begin
            n_err++;
            $display("FAIL rst_mid: ACCESS never reached, got psel=%b pen=%b", psel, penable);
        end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({psel, penable, rsp_valid, req_ready, rsp_err, rsp_rdata} !== '0) begin
            n_err++;
            $display("FAIL rst_mid_abort: got psel=%b pen=%b rv=%b rdy=%b err=%b rd=%h want all 0",
                     psel, penable, rsp_valid, req_ready, rsp_err, rsp_rdata);
        end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({req_ready, psel, rsp_valid} !== 3'b100) begin
            n_err++;
            $display("FAIL rst_mid_release: got rdy=%b psel=%b rv=%b want 1 0 0", req_ready, psel, rsp_valid);
        end
        repeat (3) begin
            @(negedge clk);
            n_cmp++;
            if (rsp_valid !== 1'b0 || psel !== 1'b0) begin
                n_err++;
                $display("FAIL rst_mid_quiet: got rv=%b psel=%b want 0 0", rsp_valid, psel);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] addrs [3];
        logic [AW-1:0] setup_q[$];
        int            acc_c [3];
        int            idx;
        int            rsp_n;
        bit            accepting;
        for (int i = 0; i < 3; i++) begin
            addrs[i] = AW'($urandom);
            acc_c[i] = -1;
        end
        idx   = 0;
        rsp_n = 0;
        @(negedge clk);
        pready    = 1'b1;
        pslver    = 1'b0;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = addrs[0];
        req_wdata = $urandom;
        for (int c = 0; c < 15; c++) begin
            if (c > 0) @(negedge clk);
            if (psel && !penable) setup_q.push_back(paddr);
            if (rsp_valid) rsp_n++;
            accepting = req_ready && req_valid;
            if (accepting) acc_c[idx] = c;
            @(posedge clk);
            #1;
            if (accepting) begin
                idx++;
                if (idx < 3) begin
                    req_addr  = addrs[idx];
                    req_wdata = $urandom;
                end else begin
                    req_valid = 1'b0;
                end
            end
        end
        pready = 1'b0;
        n_cmp++;
        if (acc_c[1] - acc_c[0] != 3 || acc_c[2] - acc_c[1] != 3) begin
            n_err++;
            $display("FAIL b2b_spacing: got accepts at %0d %0d %0d want 3 apart", acc_c[0], acc_c[1], acc_c[2]);
        end
        n_cmp++;
        if (rsp_n != 3) begin
            n_err++;
            $display("FAIL b2b_rsp_count: got %0d want 3", rsp_n);
        end
        n_cmp++;
        if (setup_q.size() != 3) begin
            n_err++;
            $display("FAIL b2b_setup_count: got %0d want 3", setup_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_cmp++;
                if (setup_q[i] !== addrs[i]) begin
                    n_err++;
                    $display("FAIL b2b_addr_order[%0d]: got %h want %h", i, setup_q[i], addrs[i]);
                end
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        pready    = 1'b0;
        pslver    = 1'b0;
        prdata    = '0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_reset_mid_access();
        do_txn("after_reset", 1'b0, 8'h44, 32'h0, 1, 1'b0, 32'hCAFEF00D);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
